fxp32_add_arbiter: RTL and testbench

Round-robin scheduler that shares one 32-bit fixed-point carry-lookahead adder among `NUM_REQ` requesters. Each requester presents an add or subtract request with a valid/ready handshake. The block grants one request per cycle, registers operands, runs them through the shared adder and returns a tagged, registered result. It sits between the fixed-point processing lanes and the single adder instance, so lanes need no adder of their own.

---
 rtl/fxp32_add_arbiter_pkg.sv | 25 ++
 rtl/fxp32_add_arbiter_if.sv | 28 ++
 rtl/fxp32_cla32.sv | 31 +++
 rtl/fxp32_defs.vh | 7 +
 rtl/fxp32_rr_arb.sv | 37 +++
 rtl/fxp32_add_arbiter.sv | 98 +++++++++
 tb/tb_fxp32_add_arbiter.sv | 282 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/fxp32_add_arbiter_pkg.sv
// Common types for the shared fixed-point adder arbiter.
package fxp32_add_arbiter_pkg;
`include "fxp32_defs.vh"

  localparam int FXP_W = `FXP32_W;

  typedef logic [FXP_W-1:0] fxp_t;

  typedef struct packed {
    fxp_t a;
    fxp_t b;
    logic sub;
  } op_t;

  typedef struct packed {
    fxp_t s;
    logic ovf;
  } res_t;

  // Clamp direction follows the sign of A: an overflow always leaves the
  // representable range on A's side.
  function automatic fxp_t fxp_sat(input logic a_neg);
    return a_neg ? `FXP32_MIN : `FXP32_MAX;
  endfunction
endpackage

// File: rtl/fxp32_add_arbiter_if.sv
// Request/response bundle between the processing lanes and the adder arbiter.
interface fxp32_add_arbiter_if
  import fxp32_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]            in_req_valid;
  logic [NUM_REQ-1:0]            out_req_ready;
  logic [NUM_REQ-1:0][FXP_W-1:0] in_req_a;
  logic [NUM_REQ-1:0][FXP_W-1:0] in_req_b;
  logic [NUM_REQ-1:0]            in_req_sub;
  logic                          out_rsp_valid;
  logic                          in_rsp_ready;
  logic [ID_W-1:0]               out_rsp_id;
  logic [FXP_W-1:0]              out_rsp_s;
  logic                          out_rsp_overflow;

  modport master (
    output in_req_valid, in_req_a, in_req_b, in_req_sub, in_rsp_ready,
    input  out_req_ready, out_rsp_valid, out_rsp_id, out_rsp_s, out_rsp_overflow
  );

  modport slave (
    input  in_req_valid, in_req_a, in_req_b, in_req_sub, in_rsp_ready,
    output out_req_ready, out_rsp_valid, out_rsp_id, out_rsp_s, out_rsp_overflow
  );
endinterface

// File: rtl/fxp32_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module fxp32_cla32
  import fxp32_add_arbiter_pkg::*;
(
  input  fxp_t a_i,
  input  fxp_t b_i,
  input  logic cin_i,
  output fxp_t s_o,
  output logic ovf_o
);
  fxp_t        g, p;
  logic [FXP_W:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < FXP_W / 4; i++) begin
      c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+4] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
    end
    s_o   = p ^ c[FXP_W-1:0];
    ovf_o = c[FXP_W] ^ c[FXP_W-1];
  end
endmodule

// File: rtl/fxp32_defs.vh
// Shared fixed-point constants: datapath width and saturation limits.
`ifndef FXP32_DEFS_VH
`define FXP32_DEFS_VH
`define FXP32_W   32
`define FXP32_MAX 32'h7FFF_FFFF
`define FXP32_MIN 32'h8000_0000
`endif

// File: rtl/fxp32_rr_arb.sv
// Round-robin grant with a wrap-around search starting at the pointer; the
// pointer only moves past the winner when the grant is actually taken.
module fxp32_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  // NUM_REQ is a power of two, so ID_W-bit addition wraps the search for free
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_i[ptr_q + ID_W'(k)]) begin
        found       = 1'b1;
        grant_idx_o = ptr_q + ID_W'(k);
      end
    end
    if (found) grant_o[grant_idx_o] = 1'b1;
  end

  assign ptr_d = adv_i ? grant_idx_o + ID_W'(1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fxp32_add_arbiter.sv
// Shares one fixed-point CLA adder among NUM_REQ lanes: RR grant -> S1 operands -> S2 result.
// Define FXP32_ARB_SAT_EN to saturate overflowing results instead of wrapping.
module fxp32_add_arbiter
  import fxp32_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  fxp32_add_arbiter_if.slave  bus
);
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               s1_free, s2_free, req_fire;

  logic               s1_valid_q;
  op_t                s1_op_q, s1_op_d;
  logic [ID_W-1:0]    s1_id_q;
  logic               s2_valid_q;
  res_t               s2_res_q, s2_res_d;
  logic [ID_W-1:0]    s2_id_q;

  fxp_t               add_b, add_s;
  logic               add_ovf;

  // S1 drains into S2 on the same edge S2 drains out, so a full pipe still
  // accepts whenever the consumer is taking the head result.
  assign s2_free  = !s2_valid_q | bus.in_rsp_ready;
  assign s1_free  = !s1_valid_q | s2_free;
  assign bus.out_req_ready = grant & {NUM_REQ{s1_free}};
  assign req_fire = |(bus.in_req_valid & bus.out_req_ready);

  fxp32_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (bus.in_req_valid),
    .adv_i       (req_fire),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign s1_op_d = '{a:   bus.in_req_a[grant_idx],
                     b:   bus.in_req_b[grant_idx],
                     sub: bus.in_req_sub[grant_idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_id_q    <= '0;
    end else if (s1_free) begin
      s1_valid_q <= req_fire;
      if (req_fire) begin
        s1_op_q <= s1_op_d;
        s1_id_q <= grant_idx;
      end
    end
  end

  // Subtract as A + ~B + 1 through the same adder
  assign add_b = s1_op_q.sub ? ~s1_op_q.b : s1_op_q.b;

  fxp32_cla32 u_cla (
    .a_i   (s1_op_q.a),
    .b_i   (add_b),
    .cin_i (s1_op_q.sub),
    .s_o   (add_s),
    .ovf_o (add_ovf)
  );

  always_comb begin
    s2_res_d.s   = add_s;
    s2_res_d.ovf = add_ovf;
`ifdef FXP32_ARB_SAT_EN
    if (add_ovf) s2_res_d.s = fxp_sat(s1_op_q.a[FXP_W-1]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_id_q    <= '0;
    end else if (s2_free) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q <= s2_res_d;
        s2_id_q  <= s1_id_q;
      end
    end
  end

  assign bus.out_rsp_valid    = s2_valid_q;
  assign bus.out_rsp_id       = s2_id_q;
  assign bus.out_rsp_s        = s2_res_q.s;
  assign bus.out_rsp_overflow = s2_res_q.ovf;
endmodule

// File: tb/tb_fxp32_add_arbiter.sv
// Directed bench for fxp32_add_arbiter: a slot-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_fxp32_add_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fxp32_add_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
  fxp32_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        ovf;
    int          cyc;
  } rsp_t;

  int n_cmp = 0, n_fail = 0, cycn = 0;
  int rep[N];
  logic [31:0] opa[N], opb[N];
  logic opsub[N];
  rsp_t rlog[$];
  int   alog[$];
  int   acyc[$];

  // reference pipeline state
  int m_ptr;
  bit m1v, m1sub, m2v, m2o;
  logic [31:0] m1a, m1b, m2s;
  int m1id, m2id;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint r;
    logic ovf;
    logic [31:0] s;
    r   = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    s   = r[31:0];
`ifdef FXP32_ARB_SAT_EN
    if (ovf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, s};
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.in_req_valid[i] = (rep[i] != 0);
      bus.in_req_a[i]     = opa[i];
      bus.in_req_b[i]     = opb[i];
      bus.in_req_sub[i]   = opsub[i];
    end
  endtask

  // Called at the falling edge: compare, log, then advance the model for the next rising edge.
  task automatic model_step();
    int g;
    bit s1f, s2f;
    logic [N-1:0] exp_rdy;
    logic [32:0] r;
    cycn++;
    if (!rst_n) begin
      m_ptr = 0; m1v = 0; m2v = 0;
      check("rst_rsp_valid", bus.out_rsp_valid, 0);
      check("rst_req_ready", bus.out_req_ready, 0);
      check("rst_rsp_s", bus.out_rsp_s, 0);
      check("rst_rsp_id", bus.out_rsp_id, 0);
      check("rst_rsp_ovf", bus.out_rsp_overflow, 0);
      return;
    end
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && bus.in_req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    s2f = !m2v || bus.in_rsp_ready;
    s1f = !m1v || s2f;
    exp_rdy = '0;
    if (g >= 0 && s1f) exp_rdy[g] = 1'b1;
    check("req_ready", bus.out_req_ready, exp_rdy);
    check("rsp_valid", bus.out_rsp_valid, m2v);
    if (m2v) begin
      check("rsp_id", bus.out_rsp_id, m2id);
      check("rsp_s", bus.out_rsp_s, m2s);
      check("rsp_ovf", bus.out_rsp_overflow, m2o);
    end
    if (bus.out_rsp_valid && bus.in_rsp_ready)
      rlog.push_back('{id: int'(bus.out_rsp_id), s: bus.out_rsp_s, ovf: bus.out_rsp_overflow, cyc: cycn});
    for (int i = 0; i < N; i++)
      if (bus.in_req_valid[i] && bus.out_req_ready[i]) begin
        alog.push_back(i); acyc.push_back(cycn); rep[i]--;
      end
    if (s2f) begin
      if (m1v) begin
        r = ref_op(m1a, m1b, m1sub);
        m2s = r[31:0]; m2o = r[32]; m2id = m1id;
      end
      m2v = m1v;
    end
    if (s1f) begin
      m1v = (g >= 0);
      if (g >= 0) begin
        m1a = bus.in_req_a[g]; m1b = bus.in_req_b[g]; m1sub = bus.in_req_sub[g];
        m1id = g; m_ptr = (g + 1) % N;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    apply();
  endtask

  function automatic bit busy();
    bit b;
    b = m1v || m2v;
    for (int i = 0; i < N; i++) if (rep[i] != 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (busy() && k < maxc) begin cyc(); k++; end
    if (busy()) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: pipeline still busy after %0d cycles", maxc);
    end
  endtask

  // Asynchronous assert mid-cycle, release away from the rising edge
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_now_rsp_valid", bus.out_rsp_valid, 0);
    check("rst_now_req_ready", bus.out_req_ready, 0);
    @(negedge clk);
    model_step();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    opa[i] = a; opb[i] = b; opsub[i] = sub; rep[i] = 1;
  endtask

  initial begin
    int base, na, nr;
    int fair_id[6];
    fair_id = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin rep[i] = 0; opa[i] = '0; opb[i] = '0; opsub[i] = 1'b0; end
    bus.in_rsp_ready = 1'b1;
    apply();
    do_reset();

    // single request, latency
    base = rlog.size();
    set_op(0, 32'h0001_0000, 32'h0002_0000, 1'b0);
    apply();
    drain(20);
    check("single_count", rlog.size() - base, 1);
    if (rlog.size() > base) begin
      check("single_id", rlog[base].id, 0);
      check("single_s", rlog[base].s, 32'h0003_0000);
      check("single_ovf", rlog[base].ovf, 0);
      check("single_latency", rlog[base].cyc - acyc[acyc.size()-1], 2);
    end

    // fairness from a reset pointer
    do_reset();
    base = rlog.size();
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h0000_1000 * (i + 1); opb[i] = i; opsub[i] = 1'b0;
    end
    rep[0] = 2; rep[1] = 2; rep[2] = 1; rep[3] = 1;
    apply();
    drain(30);
    check("fair_count", rlog.size() - base, 6);
    if (rlog.size() >= base + 6)
      for (int k = 0; k < 6; k++) begin
        check("fair_id", rlog[base+k].id, fair_id[k]);
        check("fair_cycle", rlog[base+k].cyc - rlog[base].cyc, k);
      end

    // backpressure: two held, third waits
    base = rlog.size();
    na = alog.size();
    bus.in_rsp_ready = 1'b0;
    set_op(1, 32'h0000_0100, 32'h0000_0011, 1'b0);
    set_op(2, 32'h0000_0200, 32'h0000_0022, 1'b0);
    set_op(3, 32'h0000_0300, 32'h0000_0033, 1'b1);
    apply();
    repeat (4) cyc();
    check("bp_accepted", alog.size() - na, 2);
    check("bp_held_valid", bus.out_rsp_valid, 1);
    check("bp_held_id", bus.out_rsp_id, 2);
    check("bp_held_s", bus.out_rsp_s, 32'h0000_0222);
    bus.in_rsp_ready = 1'b1;
    drain(20);
    check("bp_count", rlog.size() - base, 3);
    if (rlog.size() >= base + 3) begin
      check("bp_id0", rlog[base].id, 2);
      check("bp_id1", rlog[base+1].id, 3);
      check("bp_s1", rlog[base+1].s, 32'h0000_02CD);
      check("bp_id2", rlog[base+2].id, 1);
      check("bp_s2", rlog[base+2].s, 32'h0000_0111);
    end

    // overflow boundaries and a negative result
    base = rlog.size();
    set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    set_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    set_op(3, 32'h0000_0005, 32'h0000_0007, 1'b1);
    apply();
    drain(20);
    check("ovf_count", rlog.size() - base, 3);
    if (rlog.size() >= base + 3) begin
      check("neg_id", rlog[base].id, 3);
      check("neg_s", rlog[base].s, 32'hFFFF_FFFE);
      check("neg_ovf", rlog[base].ovf, 0);
      check("ovf_add_id", rlog[base+1].id, 0);
      check("ovf_add_ovf", rlog[base+1].ovf, 1);
      check("ovf_sub_id", rlog[base+2].id, 1);
      check("ovf_sub_ovf", rlog[base+2].ovf, 1);
`ifdef FXP32_ARB_SAT_EN
      check("ovf_add_s", rlog[base+1].s, 32'h7FFF_FFFF);
      check("ovf_sub_s", rlog[base+2].s, 32'h8000_0000);
`else
      check("ovf_add_s", rlog[base+1].s, 32'h8000_0000);
      check("ovf_sub_s", rlog[base+2].s, 32'h7FFF_FFFF);
`endif
    end

    // reset with both stages full
    bus.in_rsp_ready = 1'b0;
    set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    set_op(1, 32'h0000_0003, 32'h0000_0004, 1'b0);
    apply();
    repeat (3) cyc();
    check("full_before_rst", bus.out_rsp_valid, 1);
    nr = rlog.size();
    do_reset();
    bus.in_rsp_ready = 1'b1;
    repeat (3) cyc();
    check("no_rsp_after_rst", rlog.size() - nr, 0);
    base = rlog.size();
    set_op(1, 32'h0000_0011, 32'h0000_0001, 1'b0);
    set_op(3, 32'h0000_0033, 32'h0000_0002, 1'b0);
    apply();
    drain(20);
    if (rlog.size() >= base + 2) begin
      check("post_rst_ptr_id0", rlog[base].id, 1);
      check("post_rst_ptr_id1", rlog[base+1].id, 3);
    end else check("post_rst_count", rlog.size() - base, 2);
    base = rlog.size();
    set_op(2, 32'h0001_2345, 32'h0000_1111, 1'b0);
    apply();
    drain(20);
    check("post_rst_req2_count", rlog.size() - base, 1);
    if (rlog.size() > base) begin
      check("post_rst_req2_id", rlog[base].id, 2);
      check("post_rst_req2_s", rlog[base].s, 32'h0001_3456);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
